// File: rtl/cache_cmd_sched.sv
// Command scheduler: queues trace commands in a FIFO and hands legal ones to the
// cache operation engine one at a time, waiting for done or a timeout in between.
//
// state | meaning
// IDLE  | pop FIFO head; legal opcode loads engine regs, illegal one is dropped
// ISSUE | eng_start high for this cycle, issue count bumps, timer loads
// WAIT  | timer counts down; leave on eng_done or terminal count
module cache_cmd_sched #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              eng_start,
  output logic [3:0]        eng_cmd,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_done,
  output logic              busy,
  output logic [15:0]       issue_cnt,
  output logic [7:0]        drop_cnt,
  output logic              timeout_err,
  input  logic              clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state;
  logic [3+ADDR_W:0]       mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [TMR_W-1:0]        wait_cnt;
  logic                    full, empty, push, pop;
  logic                    head_legal, drop_evt, to_evt;
  logic [3:0]              head_cmd;
  logic [ADDR_W-1:0]       head_addr;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;
  assign {head_cmd, head_addr} = mem[rd_ptr];

  assign head_legal = (head_cmd <= 4'd4) || (head_cmd == 4'd8) || (head_cmd == 4'd9);
  assign drop_evt   = pop && !head_legal;
  // Terminal count reached on the TIMEOUT-th WAIT cycle; done wins a tie.
  assign to_evt     = (state == WAIT) && !eng_done && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_cmd, in_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      eng_start <= 1'b0;
      eng_cmd   <= '0;
      eng_addr  <= '0;
      wait_cnt  <= '0;
      issue_cnt <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop && head_legal) begin
            eng_cmd   <= head_cmd;
            eng_addr  <= head_addr;
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 16'd1;
          wait_cnt  <= TMR_LOAD;
          state     <= WAIT;
        end
        WAIT: begin
          if (eng_done || wait_cnt == '0) state <= IDLE;
          else wait_cnt <= wait_cnt - TMR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set event in the same cycle as clr_err takes precedence over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (drop_evt) begin
        if (clr_err)                drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_err) begin
        drop_cnt <= '0;
      end
      if (to_evt)       timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_cmd_sched.sv
// Self-checking bench for cache_cmd_sched: directed scenarios plus a randomized
// run scored against a cycle-time scheduling model built on a command queue.
module tb_cache_cmd_sched;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam longint BIG = 64'h7FFF_FFFF;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_cmd = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              eng_start;
  logic [3:0]        eng_cmd;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_done = 1'b0;
  logic              busy;
  logic [15:0]       issue_cnt;
  logic [7:0]        drop_cnt;
  logic              timeout_err;
  logic              clr_err = 1'b0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  cache_cmd_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_addr(eng_addr), .eng_done(eng_done),
    .busy(busy), .issue_cnt(issue_cnt), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic bit legal_op(logic [3:0] op);
    return op inside {[4'd0:4'd4], 4'd8, 4'd9};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0; eng_done = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({in_ready, eng_start, eng_cmd, eng_addr, busy, issue_cnt, drop_cnt, timeout_err} !==
        {1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b st=%b cmd=%h addr=%h busy=%b iss=%0d drop=%0d to=%b, want 1 0 0 0 0 0 0 0",
               in_ready, eng_start, eng_cmd, eng_addr, busy, issue_cnt, drop_cnt, timeout_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); in_valid = 1'b1; in_cmd = 4'd1; in_addr = 32'h0000_1234;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    vectors++; if ({eng_start, busy} !== 2'b01) begin miscompares++; $display("FAIL single_t1: start/busy got %b want 01", {eng_start, busy}); end
    @(negedge clk);
    vectors++;
    if ({eng_start, eng_cmd, eng_addr} !== {1'b1, 4'd1, 32'h0000_1234}) begin
      miscompares++; $display("FAIL single_start: start=%b cmd=%h addr=%h want 1 1 00001234", eng_start, eng_cmd, eng_addr);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) eng_done = 1'b1;
      vectors++;
      if ({eng_start, busy, eng_cmd, eng_addr} !== {1'b0, 1'b1, 4'd1, 32'h0000_1234}) begin
        miscompares++; $display("FAIL single_hold[%0d]: start=%b busy=%b cmd=%h addr=%h", i, eng_start, busy, eng_cmd, eng_addr);
      end
    end
    @(negedge clk); eng_done = 1'b0;
    vectors++;
    if ({busy, eng_start, issue_cnt, eng_cmd} !== {1'b0, 1'b0, 16'd1, 4'd1}) begin
      miscompares++; $display("FAIL single_retire: busy=%b start=%b iss=%0d cmd=%h want 0 0 1 1", busy, eng_start, issue_cnt, eng_cmd);
    end
  endtask

  task automatic test_fill();
    int acc;
    bit found;
    logic [31:0] base, exp_a;
    acc = 0; base = 32'hA000_0000;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = (acc < 12); in_cmd = 4'd3; in_addr = base + 32'(acc);
      if (in_valid && in_ready) acc++;
    end
    @(negedge clk); in_valid = 1'b0;
    vectors++; if (acc !== 9) begin miscompares++; $display("FAIL fill_accepted: got %0d want 9", acc); end
    vectors++;
    if ({in_ready, busy, eng_addr} !== {1'b0, 1'b1, base}) begin
      miscompares++; $display("FAIL fill_full: rdy=%b busy=%b addr=%h want 0 1 %h", in_ready, busy, eng_addr, base);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); eng_done = 1'b1;
      @(negedge clk); eng_done = 1'b0;
      if (k == 1) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_pop: got %b want 0", in_ready); end
      end
      found = 1'b0;
      for (int j = 0; j < 6 && !found; j++) begin
        @(negedge clk); found = eng_start;
      end
      if (k == 1) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_back: got %b want 1", in_ready); end
      end
      exp_a = base + 32'(k);
      vectors++;
      if (!found || eng_addr !== exp_a) begin
        miscompares++; $display("FAIL fill_order[%0d]: started=%b addr=%h want 1 %h", k, found, eng_addr, exp_a);
      end
    end
    @(negedge clk);
    vectors++; if (issue_cnt !== 16'd9) begin miscompares++; $display("FAIL fill_issue_cnt: got %0d want 9", issue_cnt); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [4];
    logic [3:0] got [$];
    bit prev_start;
    ops = '{4'd5, 4'd9, 4'd15, 4'd0};
    prev_start = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eng_start) got.push_back(eng_cmd);
      eng_done = prev_start;
      prev_start = eng_start;
      in_valid = (i < 4);
      in_cmd = (i < 4) ? ops[i] : 4'd0;
      in_addr = 32'(i);
    end
    vectors++;
    if (got.size() != 2 || got[0] !== 4'd9 || got[1] !== 4'd0) begin
      miscompares++; $display("FAIL illegal_starts: got %0d starts (first=%h) want 2 starts 9,0", got.size(), (got.size() > 0) ? got[0] : 4'hx);
    end
    vectors++;
    if ({drop_cnt, issue_cnt} !== {8'd2, 16'd2}) begin
      miscompares++; $display("FAIL illegal_counts: drop=%0d iss=%0d want 2 2", drop_cnt, issue_cnt);
    end
    @(negedge clk); eng_done = 1'b0; in_valid = 1'b1; in_cmd = 4'd7;
    @(negedge clk); in_valid = 1'b0; clr_err = 1'b1;
    @(negedge clk);
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL clr_with_drop: got %0d want 1", drop_cnt); end
    @(negedge clk); clr_err = 1'b0;
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_alone: got %0d want 0", drop_cnt); end
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL illegal_no_start: got %b want 0", eng_start); end
  endtask

  task automatic test_timeout();
    int s, s2;
    do_reset();
    @(negedge clk); in_valid = 1'b1; in_cmd = 4'd2; in_addr = 32'h0000_2000;
    @(negedge clk); in_cmd = 4'd3; in_addr = 32'h0000_3000;
    @(negedge clk); in_valid = 1'b0; s = cyc;
    vectors++; if ({eng_start, eng_cmd} !== {1'b1, 4'd2}) begin miscompares++; $display("FAIL to_first_start: start=%b cmd=%h want 1 2", eng_start, eng_cmd); end
    while (cyc < s + TIMEOUT) @(negedge clk);
    vectors++; if ({timeout_err, busy} !== 2'b01) begin miscompares++; $display("FAIL to_before: err/busy got %b want 01", {timeout_err, busy}); end
    @(negedge clk);
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_set: got %b want 1 at s+%0d", timeout_err, TIMEOUT + 1); end
    @(negedge clk); s2 = cyc;
    vectors++;
    if ({eng_start, eng_cmd, eng_addr} !== {1'b1, 4'd3, 32'h0000_3000}) begin
      miscompares++; $display("FAIL to_next_issue: start=%b cmd=%h addr=%h want 1 3 00003000", eng_start, eng_cmd, eng_addr);
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    while (cyc < s2 + TIMEOUT) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    vectors++; if ({timeout_err, busy} !== 2'b00) begin miscompares++; $display("FAIL to_done_tie: err/busy got %b want 00", {timeout_err, busy}); end
  endtask

  task automatic test_done_in_issue();
    do_reset();
    @(negedge clk); in_valid = 1'b1; in_cmd = 4'd4; in_addr = 32'h0000_4444;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL dii_start: got %b want 1", eng_start); end
    eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({busy, eng_start} !== 2'b10) begin miscompares++; $display("FAIL dii_wait[%0d]: busy/start got %b want 10", i, {busy, eng_start}); end
    end
    eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    vectors++;
    if ({busy, issue_cnt, timeout_err} !== {1'b0, 16'd1, 1'b0}) begin
      miscompares++; $display("FAIL dii_retire: busy=%b iss=%0d err=%b want 0 1 0", busy, issue_cnt, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_cmd = 4'd1; in_addr = 32'(i + 16);
    end
    @(negedge clk); in_valid = 1'b0;
    vectors++; if ({busy, eng_addr} !== {1'b1, 32'd16}) begin miscompares++; $display("FAIL rmid_pre: busy=%b addr=%h want 1 10", busy, eng_addr); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, eng_start, eng_cmd, eng_addr, busy, issue_cnt, drop_cnt, timeout_err} !==
        {1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      miscompares++; $display("FAIL rmid_async: rdy=%b st=%b cmd=%h addr=%h busy=%b iss=%0d", in_ready, eng_start, eng_cmd, eng_addr, busy, issue_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({eng_start, in_ready, busy, issue_cnt} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
        miscompares++; $display("FAIL rmid_after[%0d]: st=%b rdy=%b busy=%b iss=%0d want 0 1 0 0", i, eng_start, in_ready, busy, issue_cnt);
      end
    end
  endtask

  // Scheduling model: the FIFO is a queue; the engine side is idle from free_at on.
  // A legal pop in cycle c starts in c+1; WAIT ends on done (c+d) or after TIMEOUT cycles.
  task automatic test_random();
    ent_t q [$];
    ent_t cur, nxt, h;
    longint c, start_at, free_at, done_at, to_at;
    int n_issue, n_drop, d, r;
    bit have_cur, full_before, draining, finished;
    start_at = -1; free_at = 0; done_at = -1; to_at = BIG;
    n_issue = 0; n_drop = 0; have_cur = 1'b0; finished = 1'b0;
    cur = '0; nxt = '0;
    do_reset();
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      c = longint'(cyc);
      draining = (k >= 3000);
      if (draining && q.size() == 0 && c >= free_at) begin
        finished = 1'b1;
        break;
      end
      if (c == start_at) begin
        n_issue++; have_cur = 1'b1; cur = nxt;
        r = $urandom_range(0, 24);
        d = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
        if (d == 0) begin
          done_at = -1; free_at = c + TIMEOUT + 1;
          if (to_at == BIG) to_at = free_at;
        end else begin
          done_at = c + d; free_at = c + d + 1;
        end
      end
      vectors++; if (eng_start !== (c == start_at)) begin miscompares++; $display("FAIL rnd_start @%0d: got %b want %b", c, eng_start, (c == start_at)); end
      vectors++; if (in_ready !== (q.size() < DEPTH)) begin miscompares++; $display("FAIL rnd_ready @%0d: got %b want %b", c, in_ready, (q.size() < DEPTH)); end
      vectors++; if (busy !== (c < free_at || q.size() > 0)) begin miscompares++; $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, (c < free_at || q.size() > 0)); end
      vectors++; if (timeout_err !== (c >= to_at)) begin miscompares++; $display("FAIL rnd_timeout_err @%0d: got %b want %b", c, timeout_err, (c >= to_at)); end
      if (have_cur) begin
        vectors++;
        if ({eng_cmd, eng_addr} !== {cur.cmd, cur.addr}) begin
          miscompares++; $display("FAIL rnd_cmd @%0d: got %h/%h want %h/%h", c, eng_cmd, eng_addr, cur.cmd, cur.addr);
        end
      end
      eng_done = (c == done_at);
      full_before = (q.size() >= DEPTH);
      if (c >= free_at && q.size() > 0) begin
        h = q.pop_front();
        if (legal_op(h.cmd)) begin
          start_at = c + 1; free_at = BIG; nxt = h;
        end else begin
          n_drop++;
        end
      end
      in_valid = !draining && ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      in_cmd = (r < 7) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      in_addr = $urandom;
      if (in_valid && !full_before) q.push_back({in_cmd, in_addr});
    end
    in_valid = 1'b0; eng_done = 1'b0;
    vectors++; if (!finished) begin miscompares++; $display("FAIL rnd_drain: queue %0d left, cycle budget expired", q.size()); end
    vectors++;
    if ({issue_cnt, drop_cnt} !== {16'(n_issue), 8'((n_drop > 255) ? 255 : n_drop)}) begin
      miscompares++; $display("FAIL rnd_counts: iss=%0d drop=%0d want %0d %0d", issue_cnt, drop_cnt, n_issue, n_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_timeout();
    test_done_in_issue();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
